// File: rtl/gpr_dump_unit_if.sv
// Register-dump stream: one (index, value) word per valid/ready handshake.
interface gpr_dump_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              dout_valid;
    logic              dout_ready;
    logic [ADDR_W-1:0] dout_idx;
    logic [DATA_W-1:0] dout_data;

    modport master (
        output dout_valid,
        output dout_idx,
        output dout_data,
        input  dout_ready
    );

    modport slave (
        input  dout_valid,
        input  dout_idx,
        input  dout_data,
        output dout_ready
    );
endinterface

// File: rtl/gpr_dump_unit.sv
// GPR dump engine: halts the core, reads every register, streams (idx, value); first word HALT_SETTLE+2 edges after start.
// One word per 2 cycles with ready high; a stalled word holds idx/data/gpr_addr stable until accepted.
module gpr_dump_unit #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int HALT_SETTLE = 2,
    parameter int SKIP_ZERO   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              halt,
    output logic [ADDR_W-1:0] gpr_addr,
    input  logic [DATA_W-1:0] gpr_data,
    output logic              busy,
    output logic              finish,
    gpr_dump_unit_if.master   dout
);
    localparam int CNT_W = (HALT_SETTLE > 1) ? $clog2(HALT_SETTLE) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_M1 = CNT_W'(HALT_SETTLE - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(SKIP_ZERO);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        READ,
        SEND,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            cnt             <= '0;
            halt            <= 1'b0;
            gpr_addr        <= '0;
            busy            <= 1'b0;
            finish          <= 1'b0;
            dout.dout_valid <= 1'b0;
            dout.dout_idx   <= '0;
            dout.dout_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= HALT;
                        idx   <= FIRST_IDX;
                        cnt   <= SETTLE_M1;
                        halt  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                HALT: begin
                    // gpr_addr is registered, so it must point at idx before READ samples gpr_data
                    if (cnt == '0) begin
                        state    <= READ;
                        gpr_addr <= idx;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                READ: begin
                    dout.dout_data  <= gpr_data;
                    dout.dout_idx   <= idx;
                    dout.dout_valid <= 1'b1;
                    state           <= SEND;
                end
                SEND: begin
                    if (dout.dout_ready) begin
                        dout.dout_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state  <= DONE;
                            finish <= 1'b1;
                        end else begin
                            idx      <= idx + 1'b1;
                            gpr_addr <= idx + 1'b1;
                            state    <= READ;
                        end
                    end
                end
                DONE: begin
                    // Leaving only on start=0 prevents an immediate re-dump while start is still held
                    if (!start) begin
                        state  <= IDLE;
                        finish <= 1'b0;
                        halt   <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
